// File: rtl/parallel_to_serial_pkg.sv
// Shared definitions for the parallel-to-serial shifter: FSM state encoding,
// default parameters and the counter-width helper.
package parallel_to_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } p2s_state_t;

  localparam int P2S_DEPTH_DEFAULT = 8;
  localparam int P2S_GAP_DEFAULT   = 0;

  // Bits needed to hold 0..max_value, never less than one.
  function automatic int cnt_width(input int max_value);
    int w;
    w = $clog2(max_value + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/parallel_to_serial_if.sv
// Word-in / bit-out bus of the shifter; master is the upstream/downstream
// environment, slave is the shifter itself.
interface parallel_to_serial_if
  import parallel_to_serial_pkg::*;
#(
  parameter int DEPTH = P2S_DEPTH_DEFAULT
) ();

  logic [DEPTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             stall;
  logic             out;
  logic             out_enable;
  logic             word_done;
  logic             busy;

  modport master (
    output in_data,
    output in_valid,
    output stall,
    input  in_ready,
    input  out,
    input  out_enable,
    input  word_done,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  stall,
    output in_ready,
    output out,
    output out_enable,
    output word_done,
    output busy
  );

endinterface

// File: rtl/parallel_to_serial_down_counter.sv
// Loadable down counter with zero and one-remaining flags; load wins over
// decrement and the count never wraps below zero.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_one
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);
  assign o_one  = (r_count == WIDTH'(1));

endmodule

// File: rtl/parallel_to_serial.sv
// Serializes DEPTH-bit words MSB first with one-edge latency, honouring a
// downstream stall and inserting GAP idle cycles after every word.
module parallel_to_serial
  import parallel_to_serial_pkg::*;
#(
  parameter int DEPTH = P2S_DEPTH_DEFAULT,
  parameter int GAP   = P2S_GAP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  parallel_to_serial_if.slave  bus
);

  localparam int BIT_W = cnt_width(DEPTH);
  localparam int GAP_W = cnt_width(GAP);

  p2s_state_t       r_state;
  logic [DEPTH-1:0] r_shift;
  logic             r_out;
  logic             r_out_enable;
  logic             r_word_done;
  logic             r_busy;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_issue_held;
  logic             w_word_exit;
  logic             w_gap_exit;
  logic             w_bit_zero;
  logic             w_bit_one;
  logic             w_gap_zero;
  logic             w_gap_one;
  logic             w_gap_load;
  logic             w_gap_dec;
  logic [BIT_W-1:0] w_bit_load_value;

  // In SHIFT the bit counter holds bits not yet issued; zero means the last
  // bit is on out and the next word may start at this very edge.
  always_comb begin
    w_in_ready = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE:  w_in_ready = 1'b1;
        ST_SHIFT: w_in_ready = w_bit_zero && !bus.stall && (GAP == 0);
        default:  w_in_ready = 1'b0;
      endcase
    end
  end

  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_issue_held = (r_state == ST_SHIFT) && !w_bit_zero && !bus.stall;
  assign w_word_exit  = (r_state == ST_SHIFT) && w_bit_zero && !w_accept;
  assign w_gap_exit   = (r_state == ST_GAP) && (w_gap_one || w_gap_zero);
  assign w_gap_load   = w_word_exit && (GAP > 0);
  assign w_gap_dec    = (r_state == ST_GAP);

  // A stalled accept keeps the whole word pending; otherwise the MSB leaves now.
  assign w_bit_load_value = bus.stall ? BIT_W'(DEPTH) : BIT_W'(DEPTH - 1);

  down_counter #(
    .WIDTH (BIT_W)
  ) u_bit_counter (
    .clk          (clk),
    .rst          (reset),
    .i_load       (w_accept),
    .i_load_value (w_bit_load_value),
    .i_dec        (w_issue_held),
    .o_zero       (w_bit_zero),
    .o_one        (w_bit_one)
  );

  down_counter #(
    .WIDTH (GAP_W)
  ) u_gap_counter (
    .clk          (clk),
    .rst          (reset),
    .i_load       (w_gap_load),
    .i_load_value (GAP_W'(GAP)),
    .i_dec        (w_gap_dec),
    .o_zero       (w_gap_zero),
    .o_one        (w_gap_one)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_out        <= 1'b0;
      r_out_enable <= 1'b0;
      r_word_done  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_out_enable <= 1'b0;
      r_word_done  <= 1'b0;
      if (w_accept) begin
        r_state <= ST_SHIFT;
        r_busy  <= 1'b1;
        if (!bus.stall) begin
          r_out        <= bus.in_data[DEPTH-1];
          r_shift      <= {bus.in_data[DEPTH-2:0], 1'b0};
          r_out_enable <= 1'b1;
        end else begin
          r_shift <= bus.in_data;
        end
      end else if (w_issue_held) begin
        r_out        <= r_shift[DEPTH-1];
        r_shift      <= {r_shift[DEPTH-2:0], 1'b0};
        r_out_enable <= 1'b1;
        r_word_done  <= w_bit_one;
      end else if (w_word_exit) begin
        if (GAP > 0) begin
          r_state <= ST_GAP;
          r_busy  <= 1'b1;
        end else begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      end else if (w_gap_exit) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out        = r_out;
  assign bus.out_enable = r_out_enable;
  assign bus.word_done  = r_word_done;
  assign bus.busy       = r_busy;

  a_done_implies_enable: assert property (
    @(posedge clk) disable iff (reset) r_word_done |-> r_out_enable
  );

  a_no_accept_in_gap: assert property (
    @(posedge clk) disable iff (reset) (r_state == ST_GAP) |-> !w_in_ready
  );

  a_idle_not_busy: assert property (
    @(posedge clk) disable iff (reset) (r_state == ST_IDLE) |-> !r_busy
  );

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench: one DUT with GAP=0 and one with GAP=2, downstream bits
// reassembled MSB first and compared with hand-computed words.
module tb_parallel_to_serial;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  parallel_to_serial_if #(.DEPTH(8)) if0 ();
  parallel_to_serial_if #(.DEPTH(8)) if2 ();

  parallel_to_serial #(.DEPTH(8), .GAP(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  parallel_to_serial #(.DEPTH(8), .GAP(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if0.in_data = 8'h00; if0.in_valid = 1'b1; if0.stall = 1'b0;
    if2.in_data = 8'h00; if2.in_valid = 1'b0; if2.stall = 1'b0;
    cyc();
    total++; if (if0.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", if0.in_ready); end
    total++; if (if0.out !== 1'b0) begin bad++; $display("FAIL reset_out: got %b want 0", if0.out); end
    total++; if (if0.out_enable !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", if0.out_enable); end
    total++; if (if0.word_done !== 1'b0) begin bad++; $display("FAIL reset_wd: got %b want 0", if0.word_done); end
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", if0.busy); end
    total++; if (if2.busy !== 1'b0) begin bad++; $display("FAIL reset_busy_gap: got %b want 0", if2.busy); end
    cyc();
    reset = 1'b0;
    if0.in_valid = 1'b0;
    cyc();
    total++; if (if0.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %b want 1", if0.in_ready); end
    total++; if (if0.out_enable !== 1'b0) begin bad++; $display("FAIL idle_oe: got %b want 0", if0.out_enable); end
    $display("reset released, dut idle");
  endtask

  task automatic test_basic();
    logic [7:0] word;
    logic [7:0] rx;
    word = 8'hD6;
    rx   = 8'h00;
    if0.in_data = word; if0.in_valid = 1'b1; if0.stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 0) begin if0.in_valid = 1'b0; if0.in_data = 8'h00; end
      if (if0.out_enable) rx = {rx[6:0], if0.out};
      total++; if (if0.out_enable !== 1'b1) begin bad++; $display("FAIL basic_oe[%0d]: got %b want 1", k, if0.out_enable); end
      total++; if (if0.out !== word[7-k]) begin bad++; $display("FAIL basic_bit[%0d]: got %b want %b", k, if0.out, word[7-k]); end
      total++; if (if0.word_done !== (k == 7)) begin bad++; $display("FAIL basic_wd[%0d]: got %b want %b", k, if0.word_done, (k == 7)); end
    end
    cyc();
    total++; if (if0.out_enable !== 1'b0) begin bad++; $display("FAIL basic_after_oe: got %b want 0", if0.out_enable); end
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL basic_after_busy: got %b want 0", if0.busy); end
    total++; if (rx !== word) begin bad++; $display("FAIL basic_word: got %h want %h", rx, word); end
    $display("word %h sent, reassembled %h", word, rx);
  endtask

  task automatic test_back_to_back();
    logic [15:0] words;
    logic [15:0] rx;
    words = 16'hA53C;
    rx    = 16'h0000;
    if0.in_data = 8'hA5; if0.in_valid = 1'b1; if0.stall = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (k == 0) if0.in_data = 8'h3C;
      if (k == 8) if0.in_valid = 1'b0;
      if (if0.out_enable) rx = {rx[14:0], if0.out};
      total++; if (if0.out_enable !== 1'b1) begin bad++; $display("FAIL b2b_oe[%0d]: got %b want 1", k, if0.out_enable); end
      total++; if (if0.out !== words[15-k]) begin bad++; $display("FAIL b2b_bit[%0d]: got %b want %b", k, if0.out, words[15-k]); end
      total++; if (if0.word_done !== (k == 7 || k == 15)) begin bad++; $display("FAIL b2b_wd[%0d]: got %b want %b", k, if0.word_done, (k == 7 || k == 15)); end
      if (k < 8) begin
        total++; if (if0.in_ready !== (k == 7)) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, if0.in_ready, (k == 7)); end
      end
    end
    cyc();
    total++; if (if0.out_enable !== 1'b0) begin bad++; $display("FAIL b2b_after_oe: got %b want 0", if0.out_enable); end
    total++; if (rx !== words) begin bad++; $display("FAIL b2b_words: got %h want %h", rx, words); end
    $display("words a5,3c sent back to back, reassembled %h", rx);
  endtask

  task automatic test_stall();
    logic [7:0] word;
    logic [7:0] rx;
    logic [9:0] stall_pat;
    logic [9:0] oe_pat;
    int         pulses;
    word      = 8'hF0;
    rx        = 8'h00;
    stall_pat = 10'b0010001000;
    oe_pat    = 10'b1101110111;
    pulses    = 0;
    if0.in_data = word; if0.in_valid = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      if0.stall = stall_pat[10-j];
      cyc();
      if0.in_valid = 1'b0;
      if (if0.out_enable) begin rx = {rx[6:0], if0.out}; pulses++; end
      total++; if (if0.out_enable !== oe_pat[10-j]) begin bad++; $display("FAIL stall_oe[%0d]: got %b want %b", j, if0.out_enable, oe_pat[10-j]); end
      total++; if (if0.word_done !== (j == 10)) begin bad++; $display("FAIL stall_wd[%0d]: got %b want %b", j, if0.word_done, (j == 10)); end
    end
    if0.stall = 1'b0;
    cyc();
    total++; if (pulses !== 8) begin bad++; $display("FAIL stall_pulses: got %0d want 8", pulses); end
    total++; if (rx !== word) begin bad++; $display("FAIL stall_word: got %h want %h", rx, word); end
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL stall_after_busy: got %b want 0", if0.busy); end
    $display("word %h sent with two stalls, reassembled %h in %0d pulses", word, rx, pulses);
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] word;
    logic [7:0] rx;
    if0.in_data = 8'hFF; if0.in_valid = 1'b1; if0.stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if0.in_valid = 1'b0;
    end
    total++; if (if0.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", if0.busy); end
    reset = 1'b1;
    #1;
    total++; if (if0.out !== 1'b0) begin bad++; $display("FAIL midrst_out: got %b want 0", if0.out); end
    total++; if (if0.out_enable !== 1'b0) begin bad++; $display("FAIL midrst_oe: got %b want 0", if0.out_enable); end
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", if0.busy); end
    total++; if (if0.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", if0.in_ready); end
    word = 8'h81;
    rx   = 8'h00;
    if0.in_data = word; if0.in_valid = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if0.in_valid = 1'b0;
      if (if0.out_enable) rx = {rx[6:0], if0.out};
      total++; if (if0.out_enable !== 1'b1) begin bad++; $display("FAIL midrst_oe[%0d]: got %b want 1", k, if0.out_enable); end
      total++; if (if0.out !== word[7-k]) begin bad++; $display("FAIL midrst_bit[%0d]: got %b want %b", k, if0.out, word[7-k]); end
    end
    cyc();
    total++; if (rx !== word) begin bad++; $display("FAIL midrst_word: got %h want %h", rx, word); end
    $display("reset mid word ff, then word %h reassembled %h", word, rx);
  endtask

  task automatic test_gap();
    logic [15:0] words;
    logic [15:0] rx;
    int          gap_cycles;
    logic        exp_oe;
    words      = 16'h5AC3;
    rx         = 16'h0000;
    gap_cycles = 0;
    if2.in_data = 8'h5A; if2.in_valid = 1'b1; if2.stall = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 1) if2.in_data = 8'hC3;
      if (k == 12) if2.in_valid = 1'b0;
      if (if2.out_enable) rx = {rx[14:0], if2.out};
      if (k <= 19 && if2.busy && !if2.in_ready && !if2.out_enable) gap_cycles++;
      exp_oe = (k <= 8) || (k >= 12 && k <= 19);
      total++; if (if2.out_enable !== exp_oe) begin bad++; $display("FAIL gap_oe[%0d]: got %b want %b", k, if2.out_enable, exp_oe); end
      total++; if (if2.busy !== (k != 11)) begin bad++; $display("FAIL gap_busy[%0d]: got %b want %b", k, if2.busy, (k != 11)); end
      total++; if (if2.in_ready !== (k == 11)) begin bad++; $display("FAIL gap_ready[%0d]: got %b want %b", k, if2.in_ready, (k == 11)); end
    end
    repeat (3) cyc();
    total++; if (gap_cycles !== 2) begin bad++; $display("FAIL gap_cycles: got %0d want 2", gap_cycles); end
    total++; if (rx !== words) begin bad++; $display("FAIL gap_words: got %h want %h", rx, words); end
    total++; if (if2.busy !== 1'b0) begin bad++; $display("FAIL gap_final_busy: got %b want 0", if2.busy); end
    $display("words 5a,c3 sent with gap=2, reassembled %h, gap cycles %0d", rx, gap_cycles);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 Parameter DEPTH, default 8: word width in bits; SHALL be >= 2.
REQ-002 Parameter GAP, default 0: idle cycles inserted after each word; SHALL be >= 0.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  DEPTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  combinational; block accepts in_data at this edge.
REQ-008 stall  input  1  downstream hold; no bit issued at an edge where stall=1.
REQ-009 out  output  1  registered serial bit, MSB first.
REQ-010 out_enable  output  1  registered; 1 marks the cycle in which out carries a freshly issued bit, drives downstream shift-register enable.
REQ-011 word_done  output  1  registered; 1 in the cycle the word's last bit (in_data[0]) is on out.
REQ-012 busy  output  1  registered; 1 while a word is held or GAP cycles are pending.

Function
REQ-013 States SHALL be IDLE, SHIFT, GAP; IDLE after reset.
REQ-014 Accept SHALL occur at an edge where in_valid=1 and in_ready=1; the word is latched regardless of stall.
REQ-015 in_ready SHALL be 1 in IDLE, 1 in SHIFT only when exactly one bit remains, stall=0 and GAP=0, else 0.
REQ-016 At every edge with a held or accepted word and stall=0: out <= next bit (MSB first), out_enable <= 1, remaining count decrements.
REQ-017 At an edge with stall=1 or nothing to issue: out holds, out_enable <= 0, count unchanged.
REQ-018 An accept edge with stall=0 SHALL issue in_data[DEPTH-1] at that same edge (out_enable high in the following cycle: one-edge latency).
REQ-019 Each word SHALL produce exactly DEPTH out_enable=1 cycles, never duplicated or dropped under any stall pattern.
REQ-020 word_done SHALL be 1 only alongside out_enable=1 of the last bit.
REQ-021 After the last bit: GAP=0 -> SHIFT (if accepted at that edge) or IDLE; GAP>0 -> GAP state for exactly GAP cycles with in_ready=0, out_enable=0, then IDLE.
REQ-022 Back-to-back with GAP=0 SHALL yield continuous out_enable=1 across word boundaries (no bubble).
REQ-023 in_valid without in_ready SHALL have no effect; in_data need not be held after accept.
REQ-024 Bit counter width SHALL be clog2(DEPTH+1); GAP counter clog2(GAP+1), minimum 1.

Reset
REQ-025 reset=1 SHALL immediately force IDLE, out=0, out_enable=0, word_done=0, busy=0, counters=0, shift register=0, in_ready=0.
REQ-026 Reset mid-word SHALL discard the word; first edge after release accepts new data normally.

Structure
REQ-027 State encoding and counter-width constants SHALL live in the shared shifting package/header.
REQ-028 One sub-module, down_counter (load, decrement-enable, zero flag), SHALL be instantiated for bit and GAP counts.

Verification
REQ-029 DEPTH=8, accept 8'hD6, stall=0 -> out 1,1,0,1,0,1,1,0 on 8 consecutive out_enable cycles; word_done on 8th; downstream left_shift_register_base holds 8'hD6.
REQ-030 Back-to-back 8'hA5 then 8'h3C, GAP=0 -> 16 contiguous out_enable cycles; second accept at edge of first word's 8th bit.
REQ-031 8'hF0 with stall=1 on bit-3 and bit-6 edges -> out_enable low those cycles, still exactly 8 pulses, reassembled value 8'hF0.
REQ-032 Reset asserted after 4 bits of 8'hFF -> outputs 0 immediately; next word 8'h81 serialized cleanly, 8'h81 reassembled.
REQ-033 GAP=2, two words -> exactly 2 cycles busy=1, in_ready=0, out_enable=0 between words.
REQ-034 in_valid=1 while in_ready=0 mid-word -> in-flight bit sequence unchanged, new word taken only at REQ-015 point.
